// File: rtl/main_memory_unit_if.sv
// Cache-line request bus between the cache controller (master) and main_memory_unit (slave).
// Carries the line address, write data, read/write strobes and registered read data.
interface main_memory_unit_if;
  logic [31:0]  addr;
  logic [127:0] data_in;
  logic         write_en;
  logic         read_en;
  logic [127:0] data_out;

  modport master (
    output addr,
    output data_in,
    output write_en,
    output read_en,
    input  data_out
  );

  modport slave (
    input  addr,
    input  data_in,
    input  write_en,
    input  read_en,
    output data_out
  );
endinterface

// File: rtl/main_memory_unit.sv
// Line-organised backing store: 2^LINE_ADDR_W x 128-bit lines, one-cycle registered read.
// Optional feature MAIN_MEMORY_PRELOAD_EN: reset loads every line with its own word addresses.
module main_memory_unit #(
  parameter int LINE_ADDR_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  main_memory_unit_if.slave bus
);

  localparam int DEPTH = 1 << LINE_ADDR_W;

  logic [127:0]           mem [DEPTH];
  logic [LINE_ADDR_W-1:0] idx_p0;
  logic [127:0]           data_out_p1;
  logic                   unused_addr_bits;

`ifdef MAIN_MEMORY_PRELOAD_EN
  // Word j of line i holds its own byte address, word 0 in the top 32 bits.
  function automatic logic [127:0] preload_line(input int unsigned line);
    logic [31:0] base;
    base = 32'(line) << 4;
    return {base, base + 32'd4, base + 32'd8, base + 32'd12};
  endfunction
`endif

  // Offset bits and bits above the index field alias away.
  assign idx_p0           = bus.addr[4 +: LINE_ADDR_W];
  assign unused_addr_bits = ^{bus.addr[31:4+LINE_ADDR_W], bus.addr[3:0]};

  // Stage p0 -> p1: array update and registered read with write-first forwarding.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_p1 <= '0;
`ifdef MAIN_MEMORY_PRELOAD_EN
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= preload_line(i);
      end
`endif
    end else begin
      if (bus.write_en) begin
        mem[idx_p0] <= bus.data_in;
      end
      if (bus.read_en && bus.write_en) begin
        data_out_p1 <= bus.data_in;
      end else if (bus.read_en) begin
        data_out_p1 <= mem[idx_p0];
      end
    end
  end

  assign bus.data_out = data_out_p1;

endmodule

// File: tb/tb_main_memory_unit.sv
// Scoreboard bench for main_memory_unit: reference line array plus a queue of expected read data.
module tb_main_memory_unit;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  main_memory_unit_if bus ();

  main_memory_unit #(.LINE_ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [127:0] model [256];
  logic [127:0] sb_q [$];
  string        name_q [$];
  logic [127:0] last_out;

  function automatic logic [127:0] preload_val(input int unsigned i);
    logic [31:0] b;
    b = i << 4;
    return {b, b + 32'd4, b + 32'd8, b + 32'd12};
  endfunction

  task automatic model_reset();
`ifdef MAIN_MEMORY_PRELOAD_EN
    for (int i = 0; i < 256; i++) model[i] = preload_val(i);
`endif
    last_out = '0;
  endtask

  // One request per clock; reads push their expectation, other cycles check that data_out holds.
  task automatic issue(input logic [31:0] a, input logic [127:0] d,
                       input logic we, input logic re, input string nm);
    int unsigned idx;
    logic [127:0] exp;
    string n;
    idx = (a >> 4) & 32'hFF;
    @(negedge clk);
    bus.addr     = a;
    bus.data_in  = d;
    bus.write_en = we;
    bus.read_en  = re;
    if (re) begin
      sb_q.push_back(we ? d : model[idx]);
      name_q.push_back(nm);
    end
    if (we) model[idx] = d;
    @(posedge clk);
    #1;
    bus.write_en = 1'b0;
    bus.read_en  = 1'b0;
    if (re) begin
      exp = sb_q.pop_front();
      n   = name_q.pop_front();
      checks++;
      if (bus.data_out !== exp) begin
        errors++;
        $display("FAIL %s: data_out=%h expected=%h", n, bus.data_out, exp);
      end
      last_out = exp;
    end else begin
      checks++;
      if (bus.data_out !== last_out) begin
        errors++;
        $display("FAIL %s_hold: data_out=%h expected=%h", nm, bus.data_out, last_out);
      end
    end
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    bus.addr     = '0;
    bus.data_in  = '0;
    bus.write_en = 1'b0;
    bus.read_en  = 1'b0;
    model_reset();
    #3;
    checks++;
    if (bus.data_out !== 128'h0) begin
      errors++;
      $display("FAIL reset_out: data_out=%h expected=0", bus.data_out);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

`ifdef MAIN_MEMORY_PRELOAD_EN
  task automatic test_preload();
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    issue(32'h0000_0024, '0, 1'b0, 1'b1, "preload_rd");
    checks++;
    if (bus.data_out !== 128'h00000020_00000024_00000028_0000002C) begin
      errors++;
      $display("FAIL preload_const: data_out=%h expected=%h", bus.data_out,
               128'h00000020_00000024_00000028_0000002C);
    end
  endtask
`endif

  task automatic test_write_read();
    issue(32'h0000_0100, 128'hDEADBEEF_11111111_22222222_33333333, 1'b1, 1'b0, "wr_line16");
    issue(32'h0000_010C, '0, 1'b0, 1'b1, "rd_line16_offset");
    issue(32'h0000_0104, 128'h44444444_55555555_66666666_77777777, 1'b1, 1'b0, "wr_line16_new");
    issue(32'h0000_0100, '0, 1'b0, 1'b1, "rd_after_wr_latency");
  endtask

  task automatic test_simultaneous();
    issue(32'h0000_0040, {16{8'hA5}}, 1'b1, 1'b1, "rw_forward");
    issue(32'h0000_0000, '0, 1'b0, 1'b0, "idle_after_rw");
    issue(32'h0000_0040, '0, 1'b0, 1'b1, "rd_after_rw");
  endtask

  task automatic test_alias();
    issue(32'h0000_0010, 128'h01234567_89ABCDEF_01234567_89ABCDEF, 1'b1, 1'b0, "alias_wr");
    issue(32'h0000_1010, '0, 1'b0, 1'b1, "alias_rd");
    issue(32'hFFFF_F01F, '0, 1'b0, 1'b1, "alias_rd_high");
  endtask

  task automatic test_back_to_back();
    issue(32'h0000_0010, 128'h10101010_11111111_12121212_13131313, 1'b1, 1'b0, "b2b_wr1");
    issue(32'h0000_0020, 128'h20202020_21212121_22222222_23232323, 1'b1, 1'b0, "b2b_wr2");
    issue(32'h0000_0010, '0, 1'b0, 1'b1, "b2b_rd1");
    issue(32'h0000_0020, '0, 1'b0, 1'b1, "b2b_rd2");
    issue(32'h0000_0010, '0, 1'b0, 1'b1, "b2b_rd1_again");
  endtask

  task automatic test_async_reset();
    logic [127:0] l2;
    l2 = 128'hCAFEF00D_0BADBEEF_13579BDF_2468ACE0;
    issue(32'h0000_0020, l2, 1'b1, 1'b0, "ar_wr");
    issue(32'h0000_0020, '0, 1'b0, 1'b1, "ar_rd_nonzero");
    @(negedge clk);
    bus.addr     = 32'h0000_0020;
    bus.data_in  = ~l2;
    bus.write_en = 1'b1;
    bus.read_en  = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.data_out !== 128'h0) begin
      errors++;
      $display("FAIL ar_immediate_clear: data_out=%h expected=0", bus.data_out);
    end
    @(posedge clk);
    #1;
    bus.write_en = 1'b0;
    bus.read_en  = 1'b1;
    @(posedge clk);
    #1;
    bus.read_en = 1'b0;
    checks++;
    if (bus.data_out !== 128'h0) begin
      errors++;
      $display("FAIL ar_read_ignored: data_out=%h expected=0", bus.data_out);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    issue(32'h0000_0020, '0, 1'b0, 1'b1, "ar_line_unchanged");
  endtask

  task automatic test_random();
    logic [31:0]  a;
    logic [127:0] d;
    logic         we;
    logic         re;
    for (int i = 0; i < 16; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      issue(32'(i) << 4, d, 1'b1, 1'b0, "rnd_fill");
    end
    for (int k = 0; k < 60; k++) begin
      a  = {$urandom_range(0, 15) << 12, 20'h0} | (32'($urandom_range(0, 15)) << 4)
           | 32'($urandom_range(0, 15));
      d  = {$urandom, $urandom, $urandom, $urandom};
      we = ($urandom_range(0, 2) == 0);
      re = ($urandom_range(0, 3) != 0);
      issue(a, d, we, re, "rnd_op");
    end
  endtask

  initial begin
    test_reset();
`ifdef MAIN_MEMORY_PRELOAD_EN
    test_preload();
`endif
    test_write_read();
    test_simultaneous();
    test_alias();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
